// File: rtl/ram_rw_dp_clr.sv
// Single-port-per-direction RAM (one write, one read port) with a built-in clear
// sequencer that fills every word with INIT_VAL after reset or on request.
module ram_rw_dp_clr #(
    parameter int                 DATA_W   = 16,
    parameter int                 ADDR_W   = 7,
    parameter int                 RDW_MODE = 0,
    parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              clear_req,
    output logic [DATA_W-1:0] dout,
    output logic              rd_valid,
    output logic              busy,
    output logic              dropped
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t              state_reg;
    state_t              state_next;
    logic [ADDR_W-1:0]   clr_addr_reg;
    logic [ADDR_W-1:0]   clr_addr_next;

    logic [DATA_W-1:0]   mem [DEPTH];

    logic                mem_we;
    logic [ADDR_W-1:0]   mem_waddr;
    logic [DATA_W-1:0]   mem_wdata;
    logic                idle_wr;
    logic                idle_rd;
    logic [DATA_W-1:0]   rd_word;

    logic [DATA_W-1:0]   dout_reg;
    logic                rd_valid_reg;
    logic                dropped_reg;

    // ------------------------------------------------------------------
    // Clear sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= CLEAR;
            clr_addr_reg <= '0;
        end else begin
            state_reg    <= state_next;
            clr_addr_reg <= clr_addr_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        clr_addr_next = clr_addr_reg;
        case (state_reg)
            CLEAR: begin
                // The increment wraps to zero on the last word, so the
                // counter is already back at 0 when IDLE is entered.
                clr_addr_next = clr_addr_reg + ADDR_W'(1);
                if (&clr_addr_reg) begin
                    state_next = IDLE;
                end
            end
            IDLE: begin
                if (clear_req) begin
                    state_next    = CLEAR;
                    clr_addr_next = '0;
                end
            end
            default: begin
                state_next    = CLEAR;
                clr_addr_next = '0;
            end
        endcase
    end

    assign busy    = (state_reg == CLEAR);
    assign idle_wr = !busy && wr_en;
    assign idle_rd = !busy && rd_en;

    // ------------------------------------------------------------------
    // Memory write port: the sequencer owns it while busy. Gating with
    // rst_n keeps a held reset from repeatedly clearing word 0.
    // ------------------------------------------------------------------
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = wr_addr;
        mem_wdata = din;
        if (busy) begin
            mem_we    = rst_n;
            mem_waddr = clr_addr_reg;
            mem_wdata = INIT_VAL;
        end else begin
            mem_we    = rst_n && wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Read port: the array read sees pre-edge contents (old data); the
    // new-data variant bypasses din on an address collision.
    // ------------------------------------------------------------------
    generate
        if (RDW_MODE == 1) begin : g_rdw_new
            assign rd_word = (idle_wr && (wr_addr == rd_addr)) ? din : mem[rd_addr];
        end else begin : g_rdw_old
            assign rd_word = mem[rd_addr];
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_reg     <= '0;
            rd_valid_reg <= 1'b0;
            dropped_reg  <= 1'b0;
        end else begin
            rd_valid_reg <= idle_rd;
            dropped_reg  <= busy && (wr_en || rd_en);
            if (idle_rd) begin
                dout_reg <= rd_word;
            end
        end
    end

    assign dout     = dout_reg;
    assign rd_valid = rd_valid_reg;
    assign dropped  = dropped_reg;

endmodule

// File: tb/tb_ram_rw_dp_clr.sv
// Directed bench for ram_rw_dp_clr: two instances (old-data and new-data
// read-during-write) checked every cycle against a word-level memory model.
module tb_ram_rw_dp_clr;

    localparam int DW    = 16;
    localparam int AW    = 7;
    localparam int DEPTH = 128;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] din = '0;
    logic          rd_en = 1'b0;
    logic [AW-1:0] rd_addr = '0;
    logic          clear_req = 1'b0;

    logic [DW-1:0] dout0, dout1;
    logic          rv0, rv1, busy0, busy1, drop0, drop1;

    int compared   = 0;
    int mismatched = 0;

    ram_rw_dp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(0), .INIT_VAL(16'h0000)) dut0 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .clear_req(clear_req),
        .dout(dout0), .rd_valid(rv0), .busy(busy0), .dropped(drop0));

    ram_rw_dp_clr #(.DATA_W(DW), .ADDR_W(AW), .RDW_MODE(1), .INIT_VAL(16'h0000)) dut1 (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .din(din),
        .rd_en(rd_en), .rd_addr(rd_addr), .clear_req(clear_req),
        .dout(dout1), .rd_valid(rv1), .busy(busy1), .dropped(drop1));

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Model: memory array plus a count of clear writes still owed.
    // ------------------------------------------------------------------
    logic [DW-1:0] m_mem [DEPTH];
    int            clear_left = DEPTH;
    logic [DW-1:0] e_dout0 = '0, e_dout1 = '0;
    logic          e_rv = 1'b0, e_drop = 1'b0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clear_left = DEPTH;
            e_dout0    = '0;
            e_dout1    = '0;
            e_rv       = 1'b0;
            e_drop     = 1'b0;
        end else begin
            e_rv   = 1'b0;
            e_drop = 1'b0;
            if (clear_left > 0) begin
                e_drop = wr_en || rd_en;
                m_mem[DEPTH - clear_left] = 16'h0000;
                clear_left = clear_left - 1;
            end else begin
                if (rd_en) begin
                    e_dout0 = m_mem[rd_addr];
                    e_dout1 = (wr_en && wr_addr == rd_addr) ? din : m_mem[rd_addr];
                    e_rv    = 1'b1;
                end
                if (wr_en) m_mem[wr_addr] = din;
                if (clear_req) clear_left = DEPTH;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s @%0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        chk("dout_old", 32'(dout0), 32'(e_dout0));
        chk("dout_new", 32'(dout1), 32'(e_dout1));
        chk("rd_valid", {30'd0, rv1, rv0}, {30'd0, e_rv, e_rv});
        chk("busy", {30'd0, busy1, busy0}, {30'd0, clear_left > 0, clear_left > 0});
        chk("dropped", {30'd0, drop1, drop0}, {30'd0, e_drop, e_drop});
    end

    // One edge of stimulus, applied and released on falling edges.
    task automatic cyc(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] d,
                       input logic re, input logic [AW-1:0] ra, input logic cr);
        wr_en = we; wr_addr = wa; din = d; rd_en = re; rd_addr = ra; clear_req = cr;
        @(negedge clk);
        wr_en = 1'b0; rd_en = 1'b0; clear_req = 1'b0;
        $display("cyc we=%0b wa=%0d din=%h re=%0b ra=%0d clr=%0b -> dout0=%h dout1=%h rv=%0b busy=%0b drop=%0b",
                 we, wa, d, re, ra, cr, dout0, dout1, rv0, busy0, drop0);
    endtask

    int cnt;
    int nd;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy0), 32'd1);
        chk("rst_dout", 32'(dout0), 32'd0);
        rst_n = 1'b1;

        // Clear after reset lasts exactly DEPTH edges
        cnt = 0;
        while (busy0 && cnt < 1000) begin cnt++; @(negedge clk); end
        chk("init_clear_len", cnt, 128);

        foreach (m_mem[i]) if (i == 0 || i == 64 || i == 127) begin
            cyc(1'b0, '0, '0, 1'b1, AW'(i), 1'b0);
            chk("init_read", {15'd0, rv0, dout0}, {15'd0, 1'b1, 16'h0000});
        end

        cyc(1'b1, 7'd5, 16'hA5A5, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 7'd5, 1'b0);
        chk("rd5", {15'd0, rv0, dout0}, {15'd0, 1'b1, 16'hA5A5});
        cyc(1'b0, '0, '0, 1'b0, '0, 1'b0);
        chk("rd5_hold", {15'd0, rv0, dout0}, {15'd0, 1'b0, 16'hA5A5});

        cyc(1'b1, 7'd9, 16'h00FF, 1'b0, '0, 1'b0);
        cyc(1'b1, 7'd9, 16'h1234, 1'b1, 7'd9, 1'b0);
        chk("rdw_old", 32'(dout0), 32'h00FF);
        chk("rdw_new", 32'(dout1), 32'h1234);
        cyc(1'b0, '0, '0, 1'b1, 7'd9, 1'b0);
        chk("rdw_after", 32'(dout0), 32'h1234);

        // Different-address read and write at the same edge
        cyc(1'b1, 7'd20, 16'hBEEF, 1'b1, 7'd5, 1'b0);
        chk("rw_diff", 32'(dout1), 32'hA5A5);

        for (int a = 0; a < DEPTH; a++) cyc(1'b1, AW'(a), DW'(a), 1'b0, '0, 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 7'd100, 1'b0);
        chk("fill_rd100", 32'(dout0), 32'd100);

        cyc(1'b0, '0, '0, 1'b0, '0, 1'b1);
        cnt = 0; nd = 0;
        while (busy0 && cnt < 1000) begin
            cnt++;
            cyc(cnt == 10, 7'd3, 16'hFFFF, cnt == 20, 7'd4, cnt == 30);
            if (drop0) nd++;
        end
        chk("clr_len", cnt, 128);
        chk("clr_drops", nd, 2);
        chk("clr_dout_hold", 32'(dout0), 32'd100);
        for (int a = 0; a < DEPTH; a++) cyc(1'b0, '0, '0, 1'b1, AW'(a), 1'b0);
        cyc(1'b0, '0, '0, 1'b1, 7'd3, 1'b0);
        chk("clr_rd3", 32'(dout0), 32'd0);

        // Write+read+clear_req together, then reset part-way through the clear
        cyc(1'b1, 7'd7, 16'h0777, 1'b0, '0, 1'b0);
        cyc(1'b1, 7'd8, 16'h0888, 1'b1, 7'd7, 1'b1);
        chk("combo_rd", {15'd0, busy0, dout0}, {15'd0, 1'b1, 16'h0777});
        repeat (59) cyc(1'b0, '0, '0, 1'b0, '0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("rst_mid", {12'd0, busy0, rv0, drop0, 1'b0, dout0}, {12'd0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000});
        chk("rst_mid_new", 32'(dout1), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (busy0 && cnt < 1000) begin cnt++; @(negedge clk); end
        chk("rst_clear_len", cnt, 128);
        cyc(1'b0, '0, '0, 1'b1, 7'd7, 1'b0);
        chk("rst_rd7", 32'(dout0), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/ram_rw_dp_clr.md
RAM_RW_DP_CLR -- requirements
Module: ram_rw_dp_clr

Interface
REQ-001 The block SHALL have parameter DATA_W, default 16, word width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 7, address width; DEPTH = 2**ADDR_W words (default 128).
REQ-003 The block SHALL have parameter RDW_MODE, default 0, read-during-write policy: 0 = old data, 1 = new data.
REQ-004 The block SHALL have parameter INIT_VAL, default 0, DATA_W-bit value written to every word by the clear sequencer.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 wr_en  input  1  write request.
REQ-008 wr_addr  input  ADDR_W  write address.
REQ-009 din  input  DATA_W  write data.
REQ-010 rd_en  input  1  read request.
REQ-011 rd_addr  input  ADDR_W  read address.
REQ-012 clear_req  input  1  request a full-memory clear.
REQ-013 dout  output  DATA_W  registered read data.
REQ-014 rd_valid  output  1  one-cycle pulse: dout updated this cycle.
REQ-015 busy  output  1  high while the clear sequencer owns the memory.
REQ-016 dropped  output  1  one-cycle pulse: a request arrived while busy and was discarded.

Function
REQ-017 The block SHALL have two FSM states, CLEAR and IDLE, plus an ADDR_W-bit clear counter clr_addr.
REQ-018 In CLEAR, each rising edge SHALL write INIT_VAL to mem[clr_addr] and increment clr_addr.
REQ-019 The edge that writes clr_addr = DEPTH-1 SHALL move the FSM to IDLE and reset clr_addr to 0. busy SHALL go low after that edge, so a full clear takes exactly DEPTH edges.
REQ-020 busy SHALL be high exactly while the state is CLEAR.
REQ-021 In IDLE, clear_req = 1 at an edge SHALL move the FSM to CLEAR with clr_addr = 0. The first clear write happens on the following edge.
REQ-022 clear_req SHALL be ignored while in CLEAR; it does not restart the count.
REQ-023 In IDLE, wr_en = 1 at an edge SHALL write din to mem[wr_addr].
REQ-024 In IDLE, rd_en = 1 at an edge SHALL load dout with the word at rd_addr and pulse rd_valid high for one cycle (read latency 1).
REQ-025 Without a read, dout SHALL hold its value and rd_valid SHALL be 0.
REQ-026 A read and a write to the same address at the same edge SHALL return:
- the pre-write word when RDW_MODE = 0;
- din when RDW_MODE = 1.
REQ-027 A read and a write to different addresses at the same edge SHALL both complete independently.
REQ-028 If clear_req and wr_en/rd_en are high at the same IDLE edge, the write and read SHALL still be performed and the FSM SHALL enter CLEAR.
REQ-029 wr_en or rd_en high at an edge while busy SHALL be discarded. Memory and dout stay unchanged, rd_valid stays 0, and dropped pulses high for one cycle.
REQ-030 Address inputs SHALL be used modulo DEPTH by width; no out-of-range behaviour exists.

Reset
REQ-031 rst_n low SHALL immediately force:
- state = CLEAR, clr_addr = 0;
- dout = 0, rd_valid = 0, dropped = 0, busy = 1.
REQ-032 Reset SHALL NOT directly alter memory contents; the memory is initialised by the clear sequence that starts on the first edge after rst_n rises.
REQ-033 Reset asserted mid-clear or mid-operation SHALL abort the activity and restart the clear from address 0 after release.

Verification
REQ-034 Reset release, defaults: busy = 1 for 128 edges, then 0; reading addresses 0, 64 and 127 returns 0x0000 with rd_valid pulsing one cycle after each rd_en.
REQ-035 Write/read: write 0xA5A5 to address 5, then read address 5 -> dout = 0xA5A5 one edge later, rd_valid = 1 for one cycle; the idle cycle after shows rd_valid = 0 and dout holding.
REQ-036 Same-edge write of 0x1234 and read of address 9, which holds 0x00FF:
- RDW_MODE = 0 -> dout = 0x00FF, and a subsequent read returns 0x1234;
- RDW_MODE = 1 -> dout = 0x1234.
REQ-037 clear_req after filling addresses 0..127 with their address values:
- busy is high for 128 edges;
- wr_en and rd_en asserted during that time each give a dropped pulse, and dout is unchanged;
- afterwards every address reads 0x0000.
REQ-038 rst_n pulsed low at clear edge 60 -> outputs are zero and busy = 1 immediately; after release, busy stays high for a full 128 edges.
REQ-039 clear_req pulsed again while busy -> clear completes at the original count, not extended.
